dmem_arb: RTL

DMEM_ARB -- requirements
Module: dmem_arb

---
 rtl/dmem_arb.sv | 126 ++++++++++++
 1 files changed

// File: rtl/dmem_arb.sv
// dmem_arb: two-port data-memory arbiter (core LSU port c_*, external
// loader/debug port x_*) in front of a single synchronous memory port d_*.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   c_req/c_we/c_addr/c_wdata       core request (c_we == 0 is a load)
//   c_gnt/c_rvalid/c_rdata          core grant, load-return valid and data
//   x_req/x_we/x_addr/x_wdata       external request
//   x_gnt/x_rvalid/x_rdata          external grant, load-return valid and data
//   x_lock                          external port asks to keep ownership
//   d_addr/d_we/d_wr_data           memory request (d_we == 0 when idle)
//   d_rd_data                       memory read data, one cycle after address
//
// Arbitration: the core normally wins. The external port wins when the core
// is idle or when it has been denied STARVE_LIMIT consecutive cycles.
//
// Optional feature: define DMEM_ARB_LOCK_EN to let the external port hold
// ownership with x_lock. Without it x_lock is accepted but ignored.

module dmem_arb #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_req,
  input  logic [3:0]  c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  input  logic        x_req,
  input  logic [3:0]  x_we,
  input  logic [31:0] x_addr,
  input  logic [31:0] x_wdata,
  output logic        x_gnt,
  output logic        x_rvalid,
  output logic [31:0] x_rdata,
  input  logic        x_lock,
  output logic [31:0] d_addr,
  output logic [3:0]  d_we,
  output logic [31:0] d_wr_data,
  input  logic [31:0] d_rd_data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] r_starve_cnt;
  logic       r_c_rd_pend;
  logic       r_x_rd_pend;
  logic       w_x_pri;
  logic       w_x_gnt;
  logic       w_c_gnt;

`ifdef DMEM_ARB_LOCK_EN
  logic r_lock;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lock <= 1'b0;
    end else if (w_x_gnt && x_lock) begin
      r_lock <= 1'b1;
    end else if (!x_req || (w_x_gnt && !x_lock)) begin
      r_lock <= 1'b0;
    end
  end

  assign w_x_pri = (r_starve_cnt == LIMIT) | r_lock;
`else
  logic w_unused_lock;
  assign w_unused_lock = x_lock;
  assign w_x_pri       = (r_starve_cnt == LIMIT);
`endif

  // Grants are combinational and forced low during reset so no access issues.
  always_comb begin
    w_x_gnt = rst_n & x_req & (~c_req | w_x_pri);
    w_c_gnt = rst_n & c_req & ~w_x_gnt;
  end

  // Counts consecutive denied cycles of the external port; saturates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!x_req || w_x_gnt) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != LIMIT) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // Read owner for the data returning next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_c_rd_pend <= 1'b0;
      r_x_rd_pend <= 1'b0;
    end else begin
      r_c_rd_pend <= w_c_gnt & (c_we == 4'b0000);
      r_x_rd_pend <= w_x_gnt & (x_we == 4'b0000);
    end
  end

  // A load granted just before reset asserts still has its pending flag set
  // during the first reset cycle; gating with rst_n keeps rvalid low there.
  always_comb begin
    c_rvalid = rst_n & r_c_rd_pend;
    x_rvalid = rst_n & r_x_rd_pend;
    c_rdata  = d_rd_data;
    x_rdata  = d_rd_data;
    c_gnt    = w_c_gnt;
    x_gnt    = w_x_gnt;
  end

  always_comb begin
    d_addr    = w_x_gnt ? x_addr  : c_addr;
    d_wr_data = w_x_gnt ? x_wdata : c_wdata;
    if (w_x_gnt) begin
      d_we = x_we;
    end else if (w_c_gnt) begin
      d_we = c_we;
    end else begin
      d_we = '0;
    end
  end

endmodule
